// File: rtl/lc4_div_iter.sv
// Iterative 16-bit restoring divider for LC4 DIV/MOD: one quotient bit per RUN cycle.
// Define DIV_FAST_ZERO_EN to resolve zero divisor/dividend requests one cycle after accept.

module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] g, p;
  logic [3:0]  gg, pg;
  logic [4:0]  bc;

  assign g = a & b;
  assign p = a ^ b;

  for (genvar k = 0; k < 4; k++) begin : g_blk
    logic [3:0] gb, pb, cb;
    assign gb = g[4*k +: 4];
    assign pb = p[4*k +: 4];
    assign cb[0] = bc[k];
    assign cb[1] = gb[0] | (pb[0] & bc[k]);
    assign cb[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & bc[k]);
    assign cb[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
                 | (pb[2] & pb[1] & pb[0] & bc[k]);
    assign gg[k] = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
                 | (pb[3] & pb[2] & pb[1] & gb[0]);
    assign pg[k] = &pb;
    assign sum[4*k +: 4] = pb ^ cb;
  end

  // Second-level lookahead: block carries expanded directly from cin.
  assign bc[0] = cin;
  assign bc[1] = gg[0] | (pg[0] & cin);
  assign bc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
  assign bc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
               | (pg[2] & pg[1] & pg[0] & cin);
  assign bc[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
               | (pg[3] & pg[2] & pg[1] & gg[0])
               | (pg[3] & pg[2] & pg[1] & pg[0] & cin);
  assign cout  = bc[4];
endmodule

module lc4_div_iter #(
  parameter int unsigned ITERS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gwe,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quotient,
  output logic [15:0] remainder
);
  localparam int unsigned CW = $clog2(ITERS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [15:0]     dvd_q, dvd_d;
  logic [15:0]     rem_q, rem_d;
  logic [15:0]     dsr_q, dsr_d;
  logic            dz_q, dz_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     quot_q, quot_d;
  logic [15:0]     remo_q, remo_d;

  logic [16:0]     shifted;
  logic [15:0]     diff;
  logic            no_borrow;
  logic            take;
  logic [15:0]     rem_step;
  logic [15:0]     dvd_step;

  assign shifted = {rem_q, dvd_q[15]};

  // shifted[15:0] + ~divisor + 1: carry-out means shifted[15:0] >= divisor.
  cla16 u_sub (
    .a    (shifted[15:0]),
    .b    (~dsr_q),
    .cin  (1'b1),
    .sum  (diff),
    .cout (no_borrow)
  );

  assign take     = shifted[16] | no_borrow;
  assign rem_step = take ? diff : shifted[15:0];
  assign dvd_step = {dvd_q[14:0], take};

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    dz_d    = dz_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          dsr_d   = divisor;
          dz_d    = (divisor == '0);
          dvd_d   = dividend;
          rem_d   = '0;
          cnt_d   = CW'(ITERS - 1);
          state_d = S_RUN;
`ifdef DIV_FAST_ZERO_EN
          if (divisor == '0 || dividend == '0) begin
            quot_d  = '0;
            remo_d  = '0;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_RUN: begin
        rem_d = rem_step;
        dvd_d = dvd_step;
        if (cnt_q == '0) begin
          quot_d  = dz_q ? '0 : dvd_step;
          remo_d  = dz_q ? '0 : rem_step;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
      dz_q    <= 1'b0;
      cnt_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
    end else if (gwe) begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      dsr_q   <= dsr_d;
      dz_q    <= dz_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign quotient  = quot_q;
  assign remainder = remo_q;
endmodule

// File: tb/tb_lc4_div_iter.sv
// Self-checking bench for lc4_div_iter: directed corner cases plus randomized divisions.
module tb_lc4_div_iter;
  localparam int ITERS = 16;

  logic        clk = 1'b0;
  logic        rst, gwe, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [15:0] dividend, divisor, quotient, remainder;

  int total = 0;
  int bad   = 0;

  lc4_div_iter #(.ITERS(ITERS)) dut (
    .clk       (clk),
    .rst       (rst),
    .gwe       (gwe),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_latency(input logic [15:0] a, input logic [15:0] b);
`ifdef DIV_FAST_ZERO_EN
    if (a == 0 || b == 0) return 1;
`endif
    return ITERS + 1;
  endfunction

  // Latency counts clock edges from the accept edge (inclusive) until out_valid is seen.
  task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                         input int hold, input int stall_at, input int stall_len);
    logic [15:0] eq, er, q0, r0;
    int lat, explat;
    if (b == 0) begin eq = 0; er = 0; end
    else begin eq = a / b; er = a % b; end
    explat = exp_latency(a, b);
    if (explat > stall_at) explat += stall_len;
    out_ready = (hold == 0);
    check("in_ready_idle", in_ready, 1);
    dividend = a; divisor = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = 16'($urandom); divisor = 16'($urandom);
    lat = 1;
    while (!out_valid && lat < 64) begin
      gwe = !(lat >= stall_at && lat < stall_at + stall_len);
      @(posedge clk); #1;
      lat++;
    end
    gwe = 1'b1;
    check("latency", lat, explat);
    check("out_valid", out_valid, 1);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("in_ready_busy", in_ready, 0);
    q0 = quotient; r0 = remainder;
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      dividend = 16'($urandom); divisor = 16'($urandom);
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_q", quotient, q0);
      check("hold_r", remainder, r0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("back_idle", in_ready, 1);
    check("drop_valid", out_valid, 0);
  endtask

  initial begin
    rst = 1'b1; gwe = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);

    run_div(16'd100, 16'd7, 0, 99, 0);
    run_div(16'hFFFF, 16'h0001, 0, 99, 0);
    run_div(16'h8000, 16'h8001, 0, 99, 0);
    run_div(16'hFFFF, 16'h8000, 0, 99, 0);
    run_div(16'd5, 16'd0, 0, 99, 0);
    run_div(16'd0, 16'd9, 0, 99, 0);
    run_div(16'd12345, 16'd321, 5, 99, 0);
    run_div(16'd1000, 16'd33, 0, 6, 3);

    // Reset while count==8 (7 RUN edges after accept).
    dividend = 16'd1234; divisor = 16'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_q", quotient, 0);
    check("midrst_r", remainder, 0);
    run_div(16'd42, 16'd5, 0, 99, 0);

    for (int n = 0; n < 30; n++) begin
      logic [15:0] a, b;
      case ($urandom_range(0, 3))
        0: b = 16'd0;
        1: b = 16'($urandom_range(1, 15));
        default: b = 16'($urandom);
      endcase
      a = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      run_div(a, b, int'($urandom_range(0, 3)), 99, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
